spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
Receive side of the LIF neuron ring: consumes N spike lines and converts them to per-neuron spike counts over a programmable window.
- Completed windows are snapshotted into a shadow bank.
- Counting of the next window continues while the snapshot is streamed out one neuron per beat over a valid/ready handshake.
- Sits between the neuron array spike outputs and the readout/IO logic.

Parameters:
N, 8, number of spike inputs (neurons); must be ≥2.
CNT_W, 8, per-neuron count width; counts saturate at 2^CNT_W-1.
WIN_W, 8, width of window-length control.
IDX_W, $clog2(N), width of the output neuron index.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  1 = counting windows run; 0 = counting stops.
window_len  input  WIN_W  window length in clk cycles; sampled at window start; 0 = disabled.
spike_in  input  N  spike lines, bit i = neuron i; sampled every COUNT cycle.
out_ready  input  1  consumer accepts the current beat.
overrun_clr  input  1  clears the overrun flag.
out_valid  output  1  out_data/out_idx hold a valid beat.
out_data  output  CNT_W  spike count of neuron out_idx for the last completed window.
out_idx  output  IDX_W  neuron index of the current beat, 0..N-1.
overrun  output  1  sticky: a window completed while the previous snapshot was still draining.
busy  output  1  1 while in COUNT state.

Behaviour:
- Reset (async, active-high):
  - Count FSM to IDLE, drain FSM to EMPTY.
  - All live counters, shadow bank, window counter and latched length = 0.
  - out_valid=0, out_data=0, out_idx=0, overrun=0, busy=0.
  - An in-flight beat is dropped, with no completion.
- Count FSM: IDLE, COUNT.
  - IDLE: when enable=1 and window_len≠0, latch window_len into len_q, clear the window counter, and go to COUNT. The first counting cycle is the next cycle.
  - COUNT: each cycle, for each i, live[i] = sat(live[i] + spike_in[i]); window counter increments.
  - Closing cycle: the cycle where window counter = len_q-1, i.e. the len_q-th counting cycle. Its spikes are included in the closing window's counts.
  - At the closing edge:
    - snap[i] = sat(live[i] + spike_in[i]), subject to the overrun rule below.
    - live counters and window counter clear.
    - window_len is re-sampled. If it is nonzero and enable=1, stay in COUNT; otherwise go to IDLE.
  - enable=0 in COUNT: at the next edge go to IDLE and clear live counters and the window counter. The partial window is discarded, with no snapshot. Any drain in progress continues.
  - Saturation: live[i] holds at 2^CNT_W-1 and never wraps.
- Drain FSM: EMPTY, DRAIN.
  - A window closing while EMPTY loads snap and enters DRAIN, with out_idx=0.
  - out_valid rises the cycle after the closing cycle, so latency is 1 clk.
  - In DRAIN: out_valid=1 and out_data=snap[out_idx].
  - Beat completes on out_valid & out_ready. out_idx increments; after the beat with out_idx=N-1, go to EMPTY and out_idx returns to 0.
  - With out_ready held 1, the N beats are back-to-back.
  - Stalled beat (out_valid=1, out_ready=0): out_data and out_idx stay stable; out_valid is never withdrawn.
- Overrun rule:
  - A window closing while DRAIN is active does not overwrite snap. The new counts are lost and overrun is set.
  - A window closing on the same cycle as the final beat completion counts as EMPTY: snap is loaded, no overrun, and out_valid stays 1 with out_idx=0.
  - overrun_clr clears the flag at the next edge. If overrun_clr and a new overrun event occur in the same cycle, set wins.
- Window length 1: every COUNT cycle is a closing cycle, and each neuron's count is 0 or 1.
- busy = (count FSM == COUNT).

Test Plan:
- Reset values: assert reset mid-operation with out_valid=1 -> all outputs 0 asynchronously (before the next edge). After release with enable=0, out_valid stays 0 for 20 cycles.
- Basic window: window_len=4, enable=1, out_ready=1; spike_in[0]=1 for all 4 counting cycles, spike_in[3]=1 in cycles 2–3 only -> out_valid rises 1 clk after the closing cycle, then 8 consecutive beats idx0..7 with data 4,0,0,2,0,0,0,0.
- Saturation: CNT_W=4, window_len=20, spike_in=8'hFF constant -> every beat data=15.
- Backpressure/overrun: window_len=4, out_ready=0 through the second window close -> overrun=1, beat stays idx0 with first-window data. Raise out_ready -> first-window values drain. overrun_clr pulse -> overrun=0.
- Enable drop: deassert enable at counting cycle 2 of window_len=8 -> busy=0 next cycle, no snapshot, out_valid stays 0. Re-enable -> a fresh window counts from 0.
- Boundary: final beat accepted on the same cycle a new window closes -> no overrun, out_valid stays 1 with out_idx=0 and new-window data.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts spikes per neuron over a programmable window, snapshots each
// completed window into a shadow bank and streams it out one neuron per valid/ready beat.
module spike_rate_decoder #(
   parameter int unsigned N     = 8,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned WIN_W = 8,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIN_W-1:0] window_len,
   input  logic [N-1:0]     spike_in,
   input  logic             out_ready,
   input  logic             overrun_clr,
   output logic             out_valid,
   output logic [CNT_W-1:0] out_data,
   output logic [IDX_W-1:0] out_idx,
   output logic             overrun,
   output logic             busy
);

   typedef enum logic {CntIdle, CntCount} cnt_state_e;
   typedef enum logic {DrnEmpty, DrnDrain} drn_state_e;

   localparam logic [CNT_W-1:0] CntMax  = '1;
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

   cnt_state_e       cnt_state_d, cnt_state_q;
   drn_state_e       drn_state_d, drn_state_q;
   logic [WIN_W-1:0] len_d, len_q;
   logic [WIN_W-1:0] win_d, win_q;
   logic [CNT_W-1:0] live_d [N];
   logic [CNT_W-1:0] live_q [N];
   logic [CNT_W-1:0] snap_d [N];
   logic [CNT_W-1:0] snap_q [N];
   logic [CNT_W-1:0] sum    [N];
   logic [IDX_W-1:0] idx_d, idx_q;
   logic             overrun_d, overrun_q;
   logic             start, closing, beat_done, last_beat;

   // Saturating per-neuron count including this cycle's spikes
   always_comb begin
      for (int i = 0; i < int'(N); i++) begin
         sum[i] = (spike_in[i] && (live_q[i] != CntMax)) ? live_q[i] + CNT_W'(1) : live_q[i];
      end
   end

   assign start   = enable && (window_len != '0);
   // Closing cycle is the len_q-th counting cycle of the window
   assign closing = (cnt_state_q == CntCount) && (win_q == len_q - WIN_W'(1));

   // Count FSM next state: window start, per-cycle accumulation, close and abort
   always_comb begin
      cnt_state_d = cnt_state_q;
      len_d       = len_q;
      win_d       = win_q;
      live_d      = live_q;
      case (cnt_state_q)
         CntIdle: begin
            if (start) begin
               cnt_state_d = CntCount;
               len_d       = window_len;
               win_d       = '0;
            end
         end
         CntCount: begin
            if (closing) begin
               live_d = '{default: '0};
               win_d  = '0;
               if (start) begin
                  len_d = window_len;
               end else begin
                  cnt_state_d = CntIdle;
               end
            end else if (!enable) begin
               // Partial window is discarded without a snapshot
               cnt_state_d = CntIdle;
               live_d      = '{default: '0};
               win_d       = '0;
            end else begin
               live_d = sum;
               win_d  = win_q + WIN_W'(1);
            end
         end
         default: cnt_state_d = CntIdle;
      endcase
   end

   // Drain FSM next state: beat handshake, snapshot load and overrun tracking
   always_comb begin
      drn_state_d = drn_state_q;
      idx_d       = idx_q;
      snap_d      = snap_q;
      overrun_d   = overrun_q;
      beat_done   = (drn_state_q == DrnDrain) && out_ready;
      last_beat   = beat_done && (idx_q == LastIdx);
      if (beat_done) begin
         if (last_beat) begin
            drn_state_d = DrnEmpty;
            idx_d       = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
      if (overrun_clr) begin
         overrun_d = 1'b0;
      end
      if (closing) begin
         // Final beat completing this cycle frees the bank for the new window
         if ((drn_state_q == DrnEmpty) || last_beat) begin
            snap_d      = sum;
            drn_state_d = DrnDrain;
            idx_d       = '0;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // State registers for both FSMs, counters and shadow bank
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_state_q <= CntIdle;
         drn_state_q <= DrnEmpty;
         len_q       <= '0;
         win_q       <= '0;
         idx_q       <= '0;
         overrun_q   <= 1'b0;
         for (int i = 0; i < int'(N); i++) begin
            live_q[i] <= '0;
            snap_q[i] <= '0;
         end
      end else begin
         cnt_state_q <= cnt_state_d;
         drn_state_q <= drn_state_d;
         len_q       <= len_d;
         win_q       <= win_d;
         idx_q       <= idx_d;
         overrun_q   <= overrun_d;
         for (int i = 0; i < int'(N); i++) begin
            live_q[i] <= live_d[i];
            snap_q[i] <= snap_d[i];
         end
      end
   end

   assign out_valid = (drn_state_q == DrnDrain);
   assign out_data  = snap_q[idx_q];
   assign out_idx   = idx_q;
   assign overrun   = overrun_q;
   assign busy      = (cnt_state_q == CntCount);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: directed scenarios plus random traffic against a
// window/queue-level reference model.
module tb_spike_rate_decoder;

   localparam int N     = 8;
   localparam int CNT_W = 4;
   localparam int WIN_W = 8;
   localparam int IDX_W = 3;
   localparam int MAXC  = 15;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic [WIN_W-1:0] window_len = '0;
   logic [N-1:0]     spike_in = '0;
   logic             out_ready = 1'b0;
   logic             overrun_clr = 1'b0;
   logic             out_valid;
   logic [CNT_W-1:0] out_data;
   logic [IDX_W-1:0] out_idx;
   logic             overrun;
   logic             busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: pending beats as a queue, live window as plain integer counts
   int  m_q[$];
   int  m_idx;
   int  m_cnt[N];
   int  m_cyc;
   int  m_len;
   bit  m_busy;
   bit  m_ovr;
   int  got[$];

   logic             e_valid;
   logic [IDX_W-1:0] e_idx;
   logic [CNT_W-1:0] e_data;
   logic             e_ovr;
   logic             e_busy;

   spike_rate_decoder #(
      .N    (N),
      .CNT_W(CNT_W),
      .WIN_W(WIN_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .window_len (window_len),
      .spike_in   (spike_in),
      .out_ready  (out_ready),
      .overrun_clr(overrun_clr),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_idx    (out_idx),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic void model_outputs();
      e_valid = (m_q.size() > 0);
      e_idx   = IDX_W'(m_idx);
      e_data  = (m_q.size() > 0) ? CNT_W'(m_q[0]) : '0;
      e_ovr   = m_ovr;
      e_busy  = m_busy;
   endfunction

   function automatic void model_reset();
      m_q.delete();
      m_idx  = 0;
      m_cyc  = 0;
      m_len  = 0;
      m_busy = 0;
      m_ovr  = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      model_outputs();
   endfunction

   task automatic drive(input bit en, input int wl, input logic [N-1:0] sp, input bit rdy,
                        input bit clr);
      enable      = en;
      window_len  = WIN_W'(wl);
      spike_in    = sp;
      out_ready   = rdy;
      overrun_clr = clr;
   endtask

   // One clock: record accepted beat, advance the model, return at the falling edge
   task automatic tick();
      int c_new[N];
      bit beat, closing, ovr_ev;
      if (out_valid && out_ready) got.push_back(int'(out_data));
      @(posedge clk);
      beat    = (m_q.size() > 0) && out_ready;
      closing = m_busy && (m_cyc + 1 == m_len);
      ovr_ev  = 0;
      for (int i = 0; i < N; i++) begin
         c_new[i] = m_cnt[i] + int'(spike_in[i]);
         if (c_new[i] > MAXC) c_new[i] = MAXC;
      end
      if (beat) begin
         void'(m_q.pop_front());
         m_idx = (m_q.size() == 0) ? 0 : m_idx + 1;
      end
      if (closing) begin
         if (m_q.size() == 0) begin
            for (int i = 0; i < N; i++) m_q.push_back(c_new[i]);
            m_idx = 0;
         end else begin
            ovr_ev = 1;
         end
      end
      if (overrun_clr) m_ovr = 0;
      if (ovr_ev) m_ovr = 1;
      if (!m_busy) begin
         if (enable && window_len != 0) begin
            m_busy = 1;
            m_len  = int'(window_len);
            m_cyc  = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
         end
      end else if (closing) begin
         m_cyc = 0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
         if (enable && window_len != 0) m_len = int'(window_len);
         else m_busy = 0;
      end else if (!enable) begin
         m_busy = 0;
         m_cyc  = 0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else begin
         for (int i = 0; i < N; i++) m_cnt[i] = c_new[i];
         m_cyc++;
      end
      model_outputs();
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1'b0, 0, '0, 1'b0, 1'b0);
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({out_valid, out_idx, out_data, overrun, busy} !== '0) begin
         n_bad++;
         $display("FAIL reset_power_on: got v=%b i=%0d d=%0d ovr=%b busy=%b, want all 0",
                  out_valid, out_idx, out_data, overrun, busy);
      end
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, (c == 0) ? 2 : 0, 8'hFF, 1'b0, 1'b0);
         tick();
         n_cmp++;
         if ({out_valid, out_idx, overrun, busy} !== {e_valid, e_idx, e_ovr, e_busy} ||
             (e_valid && out_data !== e_data)) begin
            n_bad++;
            $display("FAIL reset_prep c=%0d: got v=%b i=%0d d=%0d o=%b b=%b want v=%b i=%0d d=%0d o=%b b=%b",
                     c, out_valid, out_idx, out_data, overrun, busy, e_valid, e_idx, e_data, e_ovr, e_busy);
         end
      end
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 4'd2) begin
         n_bad++;
         $display("FAIL reset_prep_valid: got v=%b d=%0d, want v=1 d=2", out_valid, out_data);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, out_idx, out_data, overrun, busy} !== '0) begin
         n_bad++;
         $display("FAIL reset_async: got v=%b i=%0d d=%0d ovr=%b busy=%b, want all 0",
                  out_valid, out_idx, out_data, overrun, busy);
      end
      model_reset();
      drive(1'b0, 4, 8'hFF, 1'b1, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         n_cmp++;
         if (out_valid !== 1'b0 || busy !== e_busy || overrun !== e_ovr) begin
            n_bad++;
            $display("FAIL reset_quiet c=%0d: got v=%b b=%b o=%b, want v=0 b=%b o=%b",
                     c, out_valid, busy, overrun, e_busy, e_ovr);
         end
      end
   endtask

   task automatic test_basic();
      logic [N-1:0] sp_tab [5] = '{8'h00, 8'h01, 8'h09, 8'h09, 8'h01};
      int exp_d [8] = '{4, 0, 0, 2, 0, 0, 0, 0};
      got.delete();
      for (int c = 0; c < 15; c++) begin
         drive(1'b1, (c == 0) ? 4 : 0, (c <= 4) ? sp_tab[c] : '0, 1'b1, 1'b0);
         tick();
         n_cmp++;
         if ({out_valid, out_idx, overrun, busy} !== {e_valid, e_idx, e_ovr, e_busy} ||
             (e_valid && out_data !== e_data)) begin
            n_bad++;
            $display("FAIL basic c=%0d: got v=%b i=%0d d=%0d o=%b b=%b want v=%b i=%0d d=%0d o=%b b=%b",
                     c, out_valid, out_idx, out_data, overrun, busy, e_valid, e_idx, e_data, e_ovr, e_busy);
         end
         if (c == 3 || c == 4) begin
            n_cmp++;
            if (out_valid !== (c == 4)) begin
               n_bad++;
               $display("FAIL basic_latency c=%0d: got v=%b want v=%b", c, out_valid, c == 4);
            end
         end
      end
      n_cmp++;
      if (got.size() != 8) begin
         n_bad++;
         $display("FAIL basic_beats: got %0d beats, want 8", got.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got[i] != exp_d[i]) begin
               n_bad++;
               $display("FAIL basic_data idx %0d: got %0d want %0d", i, got[i], exp_d[i]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      got.delete();
      for (int c = 0; c < 32; c++) begin
         drive(1'b1, (c == 0) ? 20 : 0, (c <= 20) ? 8'hFF : 8'h00, 1'b1, 1'b0);
         tick();
         n_cmp++;
         if ({out_valid, out_idx, overrun, busy} !== {e_valid, e_idx, e_ovr, e_busy} ||
             (e_valid && out_data !== e_data)) begin
            n_bad++;
            $display("FAIL sat c=%0d: got v=%b i=%0d d=%0d o=%b b=%b want v=%b i=%0d d=%0d o=%b b=%b",
                     c, out_valid, out_idx, out_data, overrun, busy, e_valid, e_idx, e_data, e_ovr, e_busy);
         end
      end
      n_cmp++;
      if (got.size() != 8) begin
         n_bad++;
         $display("FAIL sat_beats: got %0d beats, want 8", got.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got[i] != 15) begin
               n_bad++;
               $display("FAIL sat_data idx %0d: got %0d want 15", i, got[i]);
            end
         end
      end
   endtask

   task automatic test_overrun();
      int exp_d [8] = '{4, 0, 4, 0, 0, 0, 0, 0};
      got.delete();
      for (int c = 0; c < 10; c++) begin
         drive(1'b1, (c == 8 || c == 9) ? 0 : 4, (c <= 4) ? 8'h05 : 8'hF0, 1'b0, 1'b0);
         tick();
         n_cmp++;
         if ({out_valid, out_idx, overrun, busy} !== {e_valid, e_idx, e_ovr, e_busy} ||
             (e_valid && out_data !== e_data)) begin
            n_bad++;
            $display("FAIL ovr c=%0d: got v=%b i=%0d d=%0d o=%b b=%b want v=%b i=%0d d=%0d o=%b b=%b",
                     c, out_valid, out_idx, out_data, overrun, busy, e_valid, e_idx, e_data, e_ovr, e_busy);
         end
      end
      n_cmp++;
      if (overrun !== 1'b1 || out_valid !== 1'b1 || out_idx !== 3'd0 || out_data !== 4'd4) begin
         n_bad++;
         $display("FAIL ovr_hold: got o=%b v=%b i=%0d d=%0d, want o=1 v=1 i=0 d=4",
                  overrun, out_valid, out_idx, out_data);
      end
      for (int c = 0; c < 10; c++) begin
         drive(1'b1, 0, '0, 1'b1, 1'b0);
         tick();
      end
      n_cmp++;
      if (got.size() != 8) begin
         n_bad++;
         $display("FAIL ovr_beats: got %0d beats, want 8", got.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got[i] != exp_d[i]) begin
               n_bad++;
               $display("FAIL ovr_data idx %0d: got %0d want %0d", i, got[i], exp_d[i]);
            end
         end
      end
      n_cmp++;
      if (overrun !== 1'b1) begin
         n_bad++;
         $display("FAIL ovr_sticky: got %b want 1", overrun);
      end
      drive(1'b1, 0, '0, 1'b1, 1'b1);
      tick();
      drive(1'b1, 0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL ovr_clear: got %b want 0", overrun);
      end
   endtask

   task automatic test_enable_drop();
      int exp_d [8] = '{8, 0, 0, 0, 0, 0, 0, 0};
      got.delete();
      for (int c = 0; c < 8; c++) begin
         drive(c < 2, 8, 8'hFF, 1'b1, 1'b0);
         tick();
         n_cmp++;
         if ({out_valid, out_idx, overrun, busy} !== {e_valid, e_idx, e_ovr, e_busy} ||
             (e_valid && out_data !== e_data)) begin
            n_bad++;
            $display("FAIL endrop c=%0d: got v=%b i=%0d d=%0d o=%b b=%b want v=%b i=%0d d=%0d o=%b b=%b",
                     c, out_valid, out_idx, out_data, overrun, busy, e_valid, e_idx, e_data, e_ovr, e_busy);
         end
         if (c >= 2) begin
            n_cmp++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
               n_bad++;
               $display("FAIL endrop_idle c=%0d: got b=%b v=%b want b=0 v=0", c, busy, out_valid);
            end
         end
      end
      for (int c = 0; c < 20; c++) begin
         drive(1'b1, (c == 0) ? 8 : 0, (c <= 8) ? 8'h01 : 8'h00, 1'b1, 1'b0);
         tick();
         n_cmp++;
         if ({out_valid, out_idx, overrun, busy} !== {e_valid, e_idx, e_ovr, e_busy} ||
             (e_valid && out_data !== e_data)) begin
            n_bad++;
            $display("FAIL reenable c=%0d: got v=%b i=%0d d=%0d o=%b b=%b want v=%b i=%0d d=%0d o=%b b=%b",
                     c, out_valid, out_idx, out_data, overrun, busy, e_valid, e_idx, e_data, e_ovr, e_busy);
         end
      end
      n_cmp++;
      if (got.size() != 8) begin
         n_bad++;
         $display("FAIL reenable_beats: got %0d beats, want 8", got.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (got[i] != exp_d[i]) begin
               n_bad++;
               $display("FAIL reenable_data idx %0d: got %0d want %0d", i, got[i], exp_d[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 44; c++) begin
         drive(1'b1, (c >= 32) ? 0 : 8, (c >= 1 && c <= 32) ? N'($urandom) : '0, 1'b1, 1'b0);
         tick();
         n_cmp++;
         if ({out_valid, out_idx, overrun, busy} !== {e_valid, e_idx, e_ovr, e_busy} ||
             (e_valid && out_data !== e_data)) begin
            n_bad++;
            $display("FAIL b2b c=%0d: got v=%b i=%0d d=%0d o=%b b=%b want v=%b i=%0d d=%0d o=%b b=%b",
                     c, out_valid, out_idx, out_data, overrun, busy, e_valid, e_idx, e_data, e_ovr, e_busy);
         end
         if (c >= 8 && c <= 39) begin
            n_cmp++;
            if (out_valid !== 1'b1 || overrun !== 1'b0) begin
               n_bad++;
               $display("FAIL b2b_stream c=%0d: got v=%b o=%b want v=1 o=0", c, out_valid, overrun);
            end
         end
      end
   endtask

   task automatic test_random();
      int wl;
      for (int c = 0; c < 800; c++) begin
         wl = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 6));
         drive(($urandom_range(0, 15) != 0), wl, N'($urandom), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 7) == 0));
         tick();
         n_cmp++;
         if ({out_valid, out_idx, overrun, busy} !== {e_valid, e_idx, e_ovr, e_busy} ||
             (e_valid && out_data !== e_data)) begin
            n_bad++;
            $display("FAIL random c=%0d: got v=%b i=%0d d=%0d o=%b b=%b want v=%b i=%0d d=%0d o=%b b=%b",
                     c, out_valid, out_idx, out_data, overrun, busy, e_valid, e_idx, e_data, e_ovr, e_busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_overrun();
      test_enable_drop();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
